// File: rtl/furv_mem_arbiter.sv
// Shares one backing memory port between the fetch and data ports of the core.
// Round-robin grant, req/ack handshakes, and a watchdog that aborts a hung memory access.
//
// state | meaning
// IDLE  | no transaction; grant a pending request and latch its address/data
// BUS   | m_req held to memory, watchdog counting
// DONE  | one-cycle ack to the granted port, then back to IDLE
module furv_mem_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned       CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q;
  logic              gnt_data_q;   // current/last grant, 1 = data port
  logic              we_q;
  logic [CNT_W-1:0]  wdog_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              timeout_err_q;
  logic              pick_data;
  logic              wdog_fire;

  // On a tie the port that did not win last time gets the bus.
  always_comb begin
    pick_data = d_req;
    if (if_req && d_req) begin
      pick_data = ~gnt_data_q;
    end
  end

  assign wdog_fire = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_data_q    <= 1'b0;
      we_q          <= 1'b0;
      wdog_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_req || d_req) begin
            gnt_data_q <= pick_data;
            we_q       <= pick_data & d_we;
            addr_q     <= pick_data ? d_addr : if_addr;
            wdata_q    <= pick_data ? d_wdata : '0;
            wdog_q     <= '0;
            state_q    <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (m_ack) begin
            if (!we_q) begin
              if (gnt_data_q) d_rdata_q  <= m_rdata;
              else            if_rdata_q <= m_rdata;
            end
            state_q <= ST_DONE;
          end else if (wdog_fire) begin
            timeout_err_q <= 1'b1;
            if (!we_q) begin
              if (gnt_data_q) d_rdata_q  <= ERR_DATA;
              else            if_rdata_q <= ERR_DATA;
            end
            state_q <= ST_DONE;
          end else begin
            wdog_q <= wdog_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          wdog_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_req       = (state_q == ST_BUS);
  assign m_we        = (state_q == ST_BUS) & we_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign if_ack      = (state_q == ST_DONE) & ~gnt_data_q;
  assign d_ack       = (state_q == ST_DONE) & gnt_data_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_furv_mem_arbiter.sv
// Scoreboard bench for furv_mem_arbiter: requester and memory models drive the ports,
// expected transactions are queued at issue time and retired on each ack.
module tb_furv_mem_arbiter;

  typedef struct {
    logic        port_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          bus_len;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        timeout_err;

  int   errors = 0;
  int   checks = 0;
  int   mem_lat = 1;
  logic mem_mute = 1'b0;
  logic stray_ack = 1'b0;
  int   bus_cyc = 0;
  int   bus_cnt = 0;

  logic [31:0] mdl_if_rdata = '0;
  logic [31:0] mdl_d_rdata = '0;

  exp_t exp_q[$];
  req_t if_pend[$];
  req_t d_pend[$];
  exp_t mon_e;

  furv_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .m_ack       (m_ack),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic issue(input logic port_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int bus_len);
    req_t r;
    exp_t e;
    r.we = we; r.addr = addr; r.wdata = wdata;
    e.port_d = port_d; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.bus_len = bus_len;
    if (port_d) d_pend.push_back(r);
    else        if_pend.push_back(r);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stray_ack = 1'b0;
    mem_mute = 1'b0;
    if_pend.delete();
    d_pend.delete();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    mdl_if_rdata = '0;
    mdl_d_rdata = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() + if_pend.size() + d_pend.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 32'(exp_q.size() + if_pend.size() + d_pend.size()), 32'd0);
    tick();
  endtask

  // Requesters: hold req until the ack cycle ends, then present the next queued request.
  always begin : requester
    logic ack_i;
    logic ack_d;
    req_t tmp;
    @(negedge clk);
    ack_i = if_ack;
    ack_d = d_ack;
    @(posedge clk);
    #1;
    if (ack_i && if_pend.size() != 0) tmp = if_pend.pop_front();
    if (ack_d && d_pend.size() != 0)  tmp = d_pend.pop_front();
    if_req  = (if_pend.size() != 0);
    if_addr = (if_pend.size() != 0) ? if_pend[0].addr : '0;
    d_req   = (d_pend.size() != 0);
    d_we    = (d_pend.size() != 0) ? d_pend[0].we : 1'b0;
    d_addr  = (d_pend.size() != 0) ? d_pend[0].addr : '0;
    d_wdata = (d_pend.size() != 0) ? d_pend[0].wdata : '0;
  end

  // Memory: acks in the mem_lat-th cycle of m_req unless muted; stray_ack forces a pulse.
  always begin : responder
    @(posedge clk);
    #4;
    if (m_req) bus_cyc++;
    else       bus_cyc = 0;
    m_ack   = (m_req && !mem_mute && bus_cyc == mem_lat) || stray_ack;
    m_rdata = mem_f(m_addr);
  end

  always @(negedge clk) begin : monitor
    if (rst) begin
      bus_cnt = 0;
    end else begin
      if (m_req) begin
        if (exp_q.size() == 0) begin
          chk("m_req_unexp", 32'(m_req), 32'd0);
        end else begin
          chk("m_addr", m_addr, exp_q[0].addr);
          chk("m_we", 32'(m_we), 32'(exp_q[0].we));
          if (exp_q[0].we) chk("m_wdata", m_wdata, exp_q[0].wdata);
          bus_cnt++;
        end
      end
      if (if_ack || d_ack) begin
        chk("dual_ack", 32'(if_ack & d_ack), 32'd0);
        if (exp_q.size() == 0) begin
          chk("ack_unexp", 32'(if_ack | d_ack), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_port", 32'(d_ack), 32'(mon_e.port_d));
          chk("bus_len", 32'(bus_cnt), 32'(mon_e.bus_len));
          if (!mon_e.we) begin
            if (mon_e.port_d) mdl_d_rdata = mon_e.rdata;
            else              mdl_if_rdata = mon_e.rdata;
          end
          chk("if_rdata", if_rdata, mdl_if_rdata);
          chk("d_rdata", d_rdata, mdl_d_rdata);
        end
        bus_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    do_reset();
    samp();
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Zero-wait fetch: m_req one cycle after req is seen, ack the cycle after that.
    tick();
    mem_lat = 1;
    issue(1'b0, 1'b0, 32'h100, 32'h0, mem_f(32'h100), 1);
    tick(); samp();
    chk("fetch_n_m_req", 32'(m_req), 32'd0);
    tick(); samp();
    chk("fetch_n1_m_req", 32'(m_req), 32'd1);
    tick(); samp();
    chk("fetch_n2_if_ack", 32'(if_ack), 32'd1);
    chk("fetch_n2_m_req", 32'(m_req), 32'd0);
    tick();
    drain(20);
    chk("fetch_if_rdata", if_rdata, 32'h0050_0093);

    // Both ports requesting from reset: data first, then strict alternation.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h0, mem_f(32'h200 + 32'(4 * i)), 1);
      issue(1'b0, 1'b0, 32'h300 + 32'(4 * i), 32'h0, mem_f(32'h300 + 32'(4 * i)), 1);
    end
    drain(60);

    // Data write with a 3-cycle memory: rdata registers untouched.
    mem_lat = 3;
    issue(1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'h0, 3);
    drain(30);
    chk("write_d_rdata_hold", d_rdata, mem_f(32'h208));
    chk("write_no_timeout", 32'(timeout_err), 32'd0);

    // Stray m_ack while idle.
    stray_ack = 1'b1;
    samp();
    chk("stray_m_req", 32'(m_req), 32'd0);
    chk("stray_acks", 32'({if_ack, d_ack}), 32'd0);
    tick();
    stray_ack = 1'b0;
    samp();
    chk("stray_after_m_req", 32'(m_req), 32'd0);
    chk("stray_after_acks", 32'({if_ack, d_ack}), 32'd0);
    chk("stray_if_rdata", if_rdata, mdl_if_rdata);
    chk("stray_d_rdata", d_rdata, mdl_d_rdata);
    tick();

    // Hung data read: watchdog aborts after 16 bus cycles with error data.
    mem_mute = 1'b1;
    issue(1'b1, 1'b0, 32'h80, 32'h0, 32'hDEAD_BEEF, 16);
    drain(60);
    mem_mute = 1'b0;
    chk("timeout_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    mem_lat = 2;
    issue(1'b0, 1'b0, 32'h104, 32'h0, mem_f(32'h104), 2);
    drain(30);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Reset in the second bus cycle, stray m_ack right after.
    mem_lat = 3;
    issue(1'b0, 1'b0, 32'h180, 32'h0, mem_f(32'h180), 3);
    tick();
    tick();
    tick();
    rst = 1'b1;
    if_pend.delete();
    tick();
    rst = 1'b0;
    stray_ack = 1'b1;
    exp_q.delete();
    mdl_if_rdata = '0;
    mdl_d_rdata = '0;
    samp();
    chk("midrst_m_req", 32'(m_req), 32'd0);
    chk("midrst_acks", 32'({if_ack, d_ack}), 32'd0);
    tick();
    stray_ack = 1'b0;
    samp();
    chk("midrst_m_req2", 32'(m_req), 32'd0);
    chk("midrst_m_we", 32'(m_we), 32'd0);
    chk("midrst_m_addr", m_addr, 32'd0);
    chk("midrst_acks2", 32'({if_ack, d_ack}), 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    tick();

    // Re-issued request completes normally.
    mem_lat = 1;
    issue(1'b0, 1'b0, 32'h180, 32'h0, mem_f(32'h180), 1);
    drain(20);
    chk("reissue_if_rdata", if_rdata, mem_f(32'h180));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
